uart_fifo_controller: RTL and testbench



---
 rtl/uart_fifo_controller.sv | 105 ++++++++++
 tb/tb_uart_fifo_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_controller.sv
// Pointer/flag controller for the 16x8 UART FIFO array (write-synchronous, read-combinational, FWFT).
// Optional level interrupt output levelIrq is enabled by defining UART_FIFO_LEVEL_IRQ_EN.
module uart_fifo_controller #(
  parameter int ADDR_BITS          = 4,
  parameter int ALMOST_FULL_LEVEL  = 12,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                 clock,
  input  logic                 nReset,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  output logic                 memWriteEnable,
  output logic [ADDR_BITS-1:0] memWriteAddress,
  output logic [ADDR_BITS-1:0] memReadAddress,
  output logic                 empty,
  output logic                 full,
  output logic                 almostFull,
  output logic                 almostEmpty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
`ifdef UART_FIFO_LEVEL_IRQ_EN
  ,
  output logic                 levelIrq
`endif
);

  localparam int CW = ADDR_BITS + 1;
  localparam logic [ADDR_BITS:0] DEPTH_C = CW'(2 ** ADDR_BITS);
  localparam logic [ADDR_BITS:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_BITS:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);
  localparam logic [ADDR_BITS:0] ONE_C   = CW'(1);

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count_next;
  logic                 push_ok;
  logic                 pop_ok;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almostFull  = (count >= AF_C);
  assign almostEmpty = (count <= AE_C);

  // A pop frees the head slot in the same edge, so a push at full is accepted alongside it.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // The array must never see a write while the controller is held in reset or being flushed.
  assign memWriteEnable  = push_ok & nReset & ~clear;
  assign memWriteAddress = wr_ptr;
  assign memReadAddress  = rd_ptr;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_BITS'(1);
      count <= count_next;
      if (push & full & ~pop) overflow  <= 1'b1;
      if (pop & empty)        underflow <= 1'b1;
    end
  end

`ifdef UART_FIFO_LEVEL_IRQ_EN
  localparam logic [ADDR_BITS:0] AF_M1_C = CW'(ALMOST_FULL_LEVEL - 1);
  localparam logic [ADDR_BITS:0] AE_P1_C = CW'(ALMOST_EMPTY_LEVEL + 1);

  // One-cycle pulse when the fill level crosses into either threshold band.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      levelIrq <= 1'b0;
    end else if (clear) begin
      levelIrq <= 1'b0;
    end else begin
      levelIrq <= ((count == AF_M1_C) && (count_next == AF_C)) ||
                  ((count == AE_P1_C) && (count_next == AE_C));
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Self-checking bench for uart_fifo_controller: a behavioural 16x8 array plus a FIFO-order scoreboard.
module tb_uart_fifo_controller;

  logic       clock = 1'b0;
  logic       nReset;
  logic       clear;
  logic       push;
  logic       pop;
  logic [7:0] wdata;
  logic       memWriteEnable;
  logic [3:0] memWriteAddress;
  logic [3:0] memReadAddress;
  logic       empty, full, almostFull, almostEmpty;
  logic [4:0] count;
  logic       overflow, underflow;
`ifdef UART_FIFO_LEVEL_IRQ_EN
  logic       levelIrq;
`endif

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  uart_fifo_controller #(.ADDR_BITS(4), .ALMOST_FULL_LEVEL(12), .ALMOST_EMPTY_LEVEL(2)) dut (
    .clock           (clock),
    .nReset          (nReset),
    .clear           (clear),
    .push            (push),
    .pop             (pop),
    .memWriteEnable  (memWriteEnable),
    .memWriteAddress (memWriteAddress),
    .memReadAddress  (memReadAddress),
    .empty           (empty),
    .full            (full),
    .almostFull      (almostFull),
    .almostEmpty     (almostEmpty),
    .count           (count),
    .overflow        (overflow),
    .underflow       (underflow)
`ifdef UART_FIFO_LEVEL_IRQ_EN
    ,
    .levelIrq        (levelIrq)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (memWriteEnable) mem[memWriteAddress] <= wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: an accepted pop presents the head word; compare it with the oldest expected word.
  always @(negedge clock) begin
    if (nReset && !clear && pop && !empty) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_data", 32'(mem[memReadAddress]), 32'hFFFF_FFFF);
      end else begin
        check("pop_data", 32'(mem[memReadAddress]), 32'(exp_q.pop_front()));
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; the task returns at the same point.
  task automatic cyc(input logic pu, input logic po, input logic [7:0] d);
    push = pu; pop = po; wdata = d;
    @(posedge clock); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; push = 1'b1;
    #1 check("we_during_clear", 32'(memWriteEnable), 32'h0);
    @(posedge clock); #1;
    clear = 1'b0; push = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nReset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; wdata = 8'h00;
    #3;
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_count", 32'(count), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_aempty", 32'(almostEmpty), 32'h1);
    check("rst_afull", 32'(almostFull), 32'h0);
    check("rst_ovf_unf", 32'({overflow, underflow}), 32'h0);
    @(negedge clock) nReset = 1'b1;
    @(posedge clock); #1;

    // Reset in the middle of a stream discards the words and any write in flight.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      cyc(1'b1, 1'b0, 8'h10 + 8'(i));
    end
    check("count_5", 32'(count), 32'h5);
    #2 push = 1'b1; wdata = 8'h99; nReset = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'h0);
    check("async_rst_empty", 32'(empty), 32'h1);
    check("async_rst_we", 32'(memWriteEnable), 32'h0);
    exp_q.delete();
    @(posedge clock);
    @(negedge clock) nReset = 1'b1; push = 1'b0;
    @(posedge clock); #1;
    exp_q.push_back(8'hA5);
    cyc(1'b1, 1'b0, 8'hA5);
    check("a5_not_empty", 32'(empty), 32'h0);
    check("a5_read_port", 32'(mem[memReadAddress]), 32'hA5);
    cyc(1'b0, 1'b1, 8'h00);
    check("a5_drained", 32'(empty), 32'h1);

    // Fill and drain three times so both pointers wrap.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 16; i++) begin
        exp_q.push_back(8'(i));
        cyc(1'b1, 1'b0, 8'(i));
        check("fill_afull", 32'(almostFull), 32'(i + 1 >= 12));
      end
      check("fill_full", 32'(full), 32'h1);
      check("fill_count", 32'(count), 32'h10);
      for (int i = 0; i < 16; i++) begin
        cyc(1'b0, 1'b1, 8'h00);
        check("drain_aempty", 32'(almostEmpty), 32'(15 - i <= 2));
      end
      check("drain_empty", 32'(empty), 32'h1);
    end

    // Overflow at full, then flush.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      cyc(1'b1, 1'b0, 8'(i));
    end
    cyc(1'b1, 1'b0, 8'hEE);
    check("ovf_count", 32'(count), 32'h10);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_head", 32'(mem[memReadAddress]), 32'h00);
    check("ovf_no_unf", 32'(underflow), 32'h0);
    do_clear();
    check("clr_ovf", 32'(overflow), 32'h0);
    check("clr_count", 32'(count), 32'h0);
    check("clr_empty", 32'(empty), 32'h1);
    check("clr_ptrs", 32'({memWriteAddress, memReadAddress}), 32'h0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      cyc(1'b1, 1'b0, 8'(i));
    end
    exp_q.push_back(8'h77);
    cyc(1'b1, 1'b1, 8'h77);
    check("simul_full_count", 32'(count), 32'h10);
    check("simul_full_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00);
    check("last_is_77", 32'(mem[memReadAddress]), 32'h77);
    cyc(1'b0, 1'b1, 8'h00);
    check("simul_full_drained", 32'(empty), 32'h1);

    // Push and pop together while empty.
    check("pre_unf", 32'(underflow), 32'h0);
    exp_q.push_back(8'h3C);
    cyc(1'b1, 1'b1, 8'h3C);
    check("simul_empty_unf", 32'(underflow), 32'h1);
    check("simul_empty_count", 32'(count), 32'h1);
    check("simul_empty_head", 32'(mem[memReadAddress]), 32'h3C);
    cyc(1'b0, 1'b1, 8'h00);
    check("unf_sticky", 32'(underflow), 32'h1);

`ifdef UART_FIFO_LEVEL_IRQ_EN
    do_clear();
    check("irq_after_clear", 32'(levelIrq), 32'h0);
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(8'h40 + 8'(i));
      cyc(1'b1, 1'b0, 8'h40 + 8'(i));
      check("irq_rise", 32'(levelIrq), 32'(i == 11));
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check("irq_fall", 32'(levelIrq), 32'(i == 9));
    end
    do_clear();
    check("irq_no_clear_pulse", 32'(levelIrq), 32'h0);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
